// File: rtl/vmem_line_serializer.sv
// rtl/vmem_line_serializer.sv - splits vector line/element requests into 32-bit word-memory transactions
// Define VMEM_SER_MISALIGN_CHK_EN to trap misaligned elements on mem_error instead of forcing alignment.
module vmem_line_serializer #(
   parameter int LINE_BITS = 256,
   parameter int WORD_BITS = 32,
   parameter int ADDR_BITS = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_valid_rd,
   input  logic                 mem_valid_wr,
   input  logic                 mem_unit,
   input  logic [1:0]           mem_sew,
   input  logic [ADDR_BITS-1:0] mem_address,
   input  logic [LINE_BITS-1:0] mem_data_wr,
   output logic                 mem_ready,
   output logic                 mem_valid_o,
   output logic [LINE_BITS-1:0] mem_data_o,
`ifdef VMEM_SER_MISALIGN_CHK_EN
   output logic                 mem_error,
`endif
   output logic                 req_valid,
   input  logic                 req_ready,
   output logic                 req_we,
   output logic [ADDR_BITS-1:0] req_addr,
   output logic [WORD_BITS-1:0] req_wdata,
   output logic [3:0]           req_be,
   input  logic                 rsp_valid,
   input  logic [WORD_BITS-1:0] rsp_rdata
);
   localparam int BEATS = LINE_BITS / WORD_BITS;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RSP, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [BW-1:0]        beat_q, beat_d;
   logic                 unit_q, unit_d;
   logic                 we_q, we_d;
   logic [1:0]           sew_q, sew_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [LINE_BITS-1:0] wdata_q, wdata_d;
   logic [LINE_BITS-1:0] data_q, data_d;
`ifdef VMEM_SER_MISALIGN_CHK_EN
   logic                 err_q, err_d;
   logic                 in_misaligned;
`endif

   logic [1:0]           off;
   logic [WORD_BITS-1:0] elem_mask;
   logic [3:0]           be_mask;
   logic [ADDR_BITS-1:0] base_addr;
   logic                 last_beat;

   // Element offset is pulled down to the element's natural alignment.
   always_comb begin
      off       = addr_q[1:0];
      elem_mask = '1;
      be_mask   = 4'hF;
      case (sew_q)
         2'd0: begin
            elem_mask = WORD_BITS'(8'hFF);
            be_mask   = 4'h1;
         end
         2'd1: begin
            off       = {addr_q[1], 1'b0};
            elem_mask = WORD_BITS'(16'hFFFF);
            be_mask   = 4'h3;
         end
         default: off = 2'b00;
      endcase
   end

   assign base_addr  = {addr_q[ADDR_BITS-1:2], 2'b00};
   assign last_beat  = !unit_q || (beat_q == BW'(BEATS - 1));
   assign mem_data_o = data_q;
`ifdef VMEM_SER_MISALIGN_CHK_EN
   assign in_misaligned = !mem_unit &&
                          ((mem_sew == 2'd1 && mem_address[0]) ||
                           (mem_sew[1] && mem_address[1:0] != 2'b00));
`endif

   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      unit_d      = unit_q;
      we_d        = we_q;
      sew_d       = sew_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      data_d      = data_q;
      mem_ready   = 1'b0;
      mem_valid_o = 1'b0;
      req_valid   = 1'b0;
      req_we      = 1'b0;
      req_addr    = '0;
      req_wdata   = '0;
      req_be      = 4'h0;
`ifdef VMEM_SER_MISALIGN_CHK_EN
      err_d       = err_q;
      mem_error   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            mem_ready = 1'b1;
            if (mem_valid_rd || mem_valid_wr) begin
               unit_d  = mem_unit;
               sew_d   = mem_sew;
               addr_d  = mem_address;
               wdata_d = mem_data_wr;
               we_d    = mem_valid_wr;
               beat_d  = '0;
               state_d = S_REQ;
`ifdef VMEM_SER_MISALIGN_CHK_EN
               err_d = in_misaligned;
               if (in_misaligned) begin
                  state_d = S_DONE;
                  if (!mem_valid_wr) data_d = '0;
               end
`endif
            end
         end
         S_REQ: begin
            req_valid = 1'b1;
            req_we    = we_q;
            if (unit_q) begin
               req_addr  = base_addr + ADDR_BITS'({beat_q, 2'b00});
               req_wdata = wdata_q[WORD_BITS*beat_q +: WORD_BITS];
               req_be    = 4'hF;
            end else begin
               req_addr  = base_addr;
               req_wdata = (wdata_q[WORD_BITS-1:0] & elem_mask) << {off, 3'b000};
               req_be    = be_mask << off;
            end
            if (req_ready) begin
               if (!we_q) begin
                  state_d = S_WAIT_RSP;
               end else if (last_beat) begin
                  state_d = S_DONE;
               end else begin
                  beat_d = beat_q + BW'(1);
               end
            end
         end
         S_WAIT_RSP: begin
            if (rsp_valid) begin
               if (unit_q) begin
                  data_d[WORD_BITS*beat_q +: WORD_BITS] = rsp_rdata;
               end else begin
                  data_d = LINE_BITS'((rsp_rdata >> {off, 3'b000}) & elem_mask);
               end
               if (last_beat) begin
                  state_d = S_DONE;
               end else begin
                  beat_d  = beat_q + BW'(1);
                  state_d = S_REQ;
               end
            end
         end
         default: begin
            mem_valid_o = !we_q;
`ifdef VMEM_SER_MISALIGN_CHK_EN
            mem_error = err_q;
`endif
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         unit_q  <= 1'b0;
         we_q    <= 1'b0;
         sew_q   <= 2'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         data_q  <= '0;
`ifdef VMEM_SER_MISALIGN_CHK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         unit_q  <= unit_d;
         we_q    <= we_d;
         sew_q   <= sew_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         data_q  <= data_d;
`ifdef VMEM_SER_MISALIGN_CHK_EN
         err_q   <= err_d;
`endif
      end
   end
endmodule
